pll_lock_supervisor: RTL and testbench

PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

---
 rtl/pll_lock_supervisor.sv | 158 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// pll_lock_supervisor
//   Holds a downstream clock domain in reset until the PLL lock flag has been
//   continuously high for STABLE_CYCLES synchronized cycles. On lock loss it
//   pulses lock_lost, counts the event and holds reset for HOLD_CYCLES before
//   requalifying.
//
// Ports:
//   clock       in   PLL output clock
//   reset       in   asynchronous active-high reset
//   locked      in   PLL lock flag, asynchronous to clock
//   clear_count in   synchronous clear of loss_count
//   rst_out     out  active-high reset for the downstream domain (registered)
//   ready       out  high only while running (registered, == !rst_out)
//   lock_lost   out  one-cycle pulse on a lock loss while running
//   loss_count  out  saturating count of lock-loss events
module pll_lock_supervisor #(
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned LOSS_CNT_W    = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  locked,
    input  logic                  clear_count,
    output logic                  rst_out,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_count
);

    // One counter is shared by the stabilize and hold phases.
    localparam int unsigned MaxCycles = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES
                                                                      : HOLD_CYCLES;
    localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
    localparam logic [CntW-1:0] StableLast = CntW'(STABLE_CYCLES - 1);
    localparam logic [CntW-1:0] HoldLast   = CntW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        StWaitLock,
        StStabilize,
        StRun,
        StHold
    } state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    locked_meta_q, locked_s_q;
    logic                    loss_evt;

    logic                    rst_out_q, rst_out_d;
    logic                    ready_q, ready_d;
    logic                    lock_lost_q, lock_lost_d;
    logic [LOSS_CNT_W-1:0]   loss_count_q, loss_count_d;

    // Two-flop synchronizer; only locked_s_q feeds the FSM.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            locked_meta_q <= 1'b0;
            locked_s_q    <= 1'b0;
        end else begin
            locked_meta_q <= locked;
            locked_s_q    <= locked_meta_q;
        end
    end

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        loss_evt = 1'b0;
        unique case (state_q)
            StWaitLock: begin
                if (locked_s_q) begin
                    state_d = StStabilize;
                    cnt_d   = '0;
                end
            end
            StStabilize: begin
                // A drop before qualification is not a loss event.
                if (!locked_s_q) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else if (cnt_q == StableLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRun: begin
                if (!locked_s_q) begin
                    state_d  = StHold;
                    cnt_d    = '0;
                    loss_evt = 1'b1;
                end
            end
            StHold: begin
                // Lock flag is ignored so the hold time is always honoured.
                if (cnt_q == HoldLast) begin
                    state_d = StWaitLock;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StWaitLock;
                cnt_d   = '0;
            end
        endcase
    end

    // Output logic: outputs are registered from the next state so they line
    // up with the state they describe.
    always_comb begin
        rst_out_d    = (state_d != StRun);
        ready_d      = (state_d == StRun);
        lock_lost_d  = loss_evt;
        loss_count_d = loss_count_q;
        if (clear_count) begin
            loss_count_d = '0;
        end else if (loss_evt && (loss_count_q != {LOSS_CNT_W{1'b1}})) begin
            loss_count_d = loss_count_q + LOSS_CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rst_out_q    <= 1'b1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            loss_count_q <= '0;
        end else begin
            rst_out_q    <= rst_out_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
            loss_count_q <= loss_count_d;
        end
    end

    assign rst_out    = rst_out_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

    localparam int unsigned STABLE = 4;
    localparam int unsigned HOLD   = 16;
    localparam int unsigned CW     = 2;

    logic          clock;
    logic          reset;
    logic          locked;
    logic          clear_count;
    logic          rst_out;
    logic          ready;
    logic          lock_lost;
    logic [CW-1:0] loss_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string         tag;
        logic          rst;
        logic          lost;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t sb[$];

    pll_lock_supervisor #(
        .STABLE_CYCLES (STABLE),
        .HOLD_CYCLES   (HOLD),
        .LOSS_CNT_W    (CW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .locked      (locked),
        .clear_count (clear_count),
        .rst_out     (rst_out),
        .ready       (ready),
        .lock_lost   (lock_lost),
        .loss_count  (loss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    task automatic push(input string tag, input logic r, input logic l, input logic [CW-1:0] c);
        exp_t e;
        e.tag  = tag;
        e.rst  = r;
        e.lost = l;
        e.cnt  = c;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL sb_empty got=0 entries exp=1");
            return;
        end
        e = sb.pop_front();
        checks++;
        assert (rst_out === e.rst) else begin
            failures++;
            $error("FAIL %s rst_out got=%b exp=%b", e.tag, rst_out, e.rst);
        end
        checks++;
        assert (ready === ~e.rst) else begin
            failures++;
            $error("FAIL %s ready got=%b exp=%b", e.tag, ready, ~e.rst);
        end
        checks++;
        assert (lock_lost === e.lost) else begin
            failures++;
            $error("FAIL %s lock_lost got=%b exp=%b", e.tag, lock_lost, e.lost);
        end
        checks++;
        assert (loss_count === e.cnt) else begin
            failures++;
            $error("FAIL %s loss_count got=%0d exp=%0d", e.tag, loss_count, e.cnt);
        end
    endtask

    // Drive inputs, queue the expectation for after the next edge, then check.
    task automatic step(input string tag, input logic lk, input logic clr,
                        input logic r, input logic l, input logic [CW-1:0] c);
        locked      = lk;
        clear_count = clr;
        push(tag, r, l, c);
        @(posedge clock);
        #1;
        pop_check();
    endtask

    task automatic run_n(input int n, input string tag, input logic lk, input logic clr,
                         input logic r, input logic l, input logic [CW-1:0] c);
        for (int i = 0; i < n; i++) step(tag, lk, clr, r, l, c);
    endtask

    // One captured single-cycle lock drop from RUN through hold and requalification.
    task automatic loss_cycle(input logic [CW-1:0] c_prev, input logic [CW-1:0] c_new,
                              input logic clr_at_loss);
        step("loss_e1", 1'b0, 1'b0, 1'b0, 1'b0, c_prev);
        step("loss_e2", 1'b1, 1'b0, 1'b0, 1'b0, c_prev);
        step("loss_e3", 1'b1, clr_at_loss, 1'b1, 1'b1, c_new);
        run_n(HOLD - 1, "hold", 1'b1, 1'b0, 1'b1, 1'b0, c_new);
        run_n(STABLE + 1, "requal", 1'b1, 1'b0, 1'b1, 1'b0, c_new);
        step("rerun", 1'b1, 1'b0, 1'b0, 1'b0, c_new);
    endtask

    task automatic async_reset();
        #3;
        reset = 1'b1;
        #1;
        push("async_rst", 1'b1, 1'b0, '0);
        pop_check();
        @(posedge clock);
        #3;
        push("rst_held", 1'b1, 1'b0, '0);
        pop_check();
        reset = 1'b0;
        #1;
        push("rst_rel", 1'b1, 1'b0, '0);
        pop_check();
    endtask

    initial begin
        reset       = 1'b1;
        locked      = 1'b0;
        clear_count = 1'b0;
        #12;
        push("reset", 1'b1, 1'b0, '0);
        pop_check();

        // Lock high from reset release: release after edge STABLE+3.
        locked = 1'b1;
        reset  = 1'b0;
        run_n(STABLE + 2, "qual", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        step("release", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);
        run_n(3, "run", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Sub-cycle glitch between edges is never captured.
        #2 locked = 1'b0;
        #2 locked = 1'b1;
        run_n(5, "glitch", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Saturating loss counter, then clear coincident with a loss.
        loss_cycle(2'd0, 2'd1, 1'b0);
        loss_cycle(2'd1, 2'd2, 1'b0);
        loss_cycle(2'd2, 2'd3, 1'b0);
        loss_cycle(2'd3, 2'd3, 1'b0);
        loss_cycle(2'd3, 2'd3, 1'b0);
        loss_cycle(2'd3, 2'd0, 1'b1);
        loss_cycle(2'd0, 2'd1, 1'b0);
        step("clear", 1'b1, 1'b1, 1'b0, 1'b0, 2'd0);
        step("post_clear", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Async reset mid-RUN, then full requalification.
        async_reset();
        run_n(STABLE + 2, "rqual", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        step("rrelease", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        // Lock drop mid-STABILIZE (counter=2) returns to wait, no loss event.
        async_reset();
        run_n(3, "stab", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        run_n(6, "stab_drop", 1'b0, 1'b0, 1'b1, 1'b0, 2'd0);
        run_n(STABLE + 2, "squal", 1'b1, 1'b0, 1'b1, 1'b0, 2'd0);
        step("srelease", 1'b1, 1'b0, 1'b0, 1'b0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
